acc_rr_scheduler: RTL and testbench

- Shares one `acc` accumulator instance among N_REQ streaming requesters using round-robin arbitration.
- Each granted requester streams a burst of cfg_len signed samples over a valid/ready handshake.
- The scheduler drives the accumulator's initialize/in_data inputs and reads back its result.
- Each burst sum is returned on a valid/ready result port, tagged with the requester id.

---
 rtl/acc_rr_scheduler.sv | 147 ++++++++++++++
 tb/tb_acc_rr_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler that time-shares one external accumulator among N_REQ
// streaming requesters and returns each burst sum tagged with its requester id.
module acc_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int D_W     = 32,
    parameter int D_W_ACC = 32,
    parameter int LEN_W   = 8,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*D_W-1:0]   req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   acc_initialize,
    output logic [D_W-1:0]         acc_in_data,
    input  logic [D_W_ACC-1:0]     acc_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [D_W_ACC-1:0]     res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             arb_found;
    logic [ID_W-1:0]  arb_id;
    logic [ID_W-1:0]  arb_id_inc;
    logic             sel_valid;
    logic [D_W-1:0]   sel_data;

    // Search upward from rr_ptr, wrapping at N_REQ; first valid requester wins.
    always_comb begin
        logic [ID_W:0] cand;
        logic [ID_W:0] inc;
        arb_found  = 1'b0;
        arb_id     = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!arb_found && req_valid[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_id    = cand[ID_W-1:0];
            end
        end
        inc = {1'b0, arb_id} + (ID_W+1)'(1);
        if (inc == (ID_W+1)'(N_REQ)) begin
            inc = '0;
        end
        arb_id_inc = inc[ID_W-1:0];
    end

    // Mux the granted requester's handshake and sample.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id_q == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*D_W +: D_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_id_d       = gnt_id_q;
        rr_ptr_d       = rr_ptr_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_q;
        req_ready      = '0;
        acc_initialize = 1'b0;
        acc_in_data    = '0;
        res_valid      = 1'b0;
        res_data       = '0;
        res_id         = '0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_id_d   = arb_id;
                    rr_ptr_d   = arb_id_inc;
                    len_d      = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                req_ready[gnt_id_q] = 1'b1;
                // Bubbles leave in_data/initialize at 0 so the accumulator holds.
                if (sel_valid) begin
                    acc_in_data    = sel_data;
                    acc_initialize = (beat_cnt_q == '0);
                    beat_cnt_d     = beat_cnt_q + LEN_W'(1);
                    if (beat_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = acc_result;
                res_id    = gnt_id_q;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples its peers' pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Self-checking bench for acc_rr_scheduler: directed scenarios plus a randomized
// run scored against a transaction-level round-robin / burst-sum model.
module tb_acc_rr_scheduler;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LW   = 8;
    localparam int IW   = 2;
    localparam int SAMP = 1500;

    logic              clk = 1'b0;
    logic              rst;
    logic [LW-1:0]     cfg_len;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              acc_initialize;
    logic [DW-1:0]     acc_in_data;
    logic [AW-1:0]     acc_result;
    logic              res_valid;
    logic              res_ready;
    logic [AW-1:0]     res_data;
    logic [IW-1:0]     res_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] stim [8];
    int            gap [8];
    logic          obs_init [8];
    logic [DW-1:0] obs_in [8];
    int            bubble_bad;
    logic [DW-1:0] samp [N][SAMP];

    always #5 clk = ~clk;

    acc_rr_scheduler #(
        .N_REQ(N), .D_W(DW), .D_W_ACC(AW), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .acc_initialize(acc_initialize), .acc_in_data(acc_in_data),
        .acc_result(acc_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    // Behavioural stand-in for the shared accumulator (same reset as the scheduler).
    always @(posedge clk) begin
        if (rst) acc_result <= '0;
        else if (acc_initialize) acc_result <= acc_in_data;
        else acc_result <= acc_result + acc_in_data;
    end

    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; res_ready = 1'b0; cfg_len = '0; req_data = '0;
        for (int i = 0; i < 8; i++) gap[i] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic stream(input int id, input int n);
        int k; int g; int budget; logic beat;
        k = 0; g = gap[0]; budget = 0; bubble_bad = 0;
        while (k < n && budget < 100) begin
            if (g > 0) req_valid[id] = 1'b0;
            else begin
                req_valid[id] = 1'b1;
                req_data[id*DW +: DW] = stim[k];
            end
            #1;
            beat = req_valid[id] && req_ready[id];
            if (beat) begin
                obs_init[k] = acc_initialize;
                obs_in[k]   = acc_in_data;
            end
            if (req_ready[id] && !req_valid[id] && (acc_initialize || acc_in_data != '0))
                bubble_bad++;
            @(posedge clk); #1;
            budget++;
            if (beat) begin
                k++;
                if (k < n) g = gap[k];
            end else if (g > 0) g--;
        end
        req_valid[id] = 1'b0;
        n_checks++;
        if (k != n) begin
            n_fail++;
            $display("FAIL stream_beats req=%0d got %0d want %0d", id, k, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; res_ready = 1'b1; cfg_len = 8'd3; req_data = '1;
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready, acc_initialize, acc_in_data, res_valid, res_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%b init=%b in=%h rv=%b id=%0d want all 0",
                     req_ready, acc_initialize, acc_in_data, res_valid, res_id);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", busy);
        end
        apply_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            n_fail++; $display("FAIL idle_after_reset got busy=%b ready=%b want 0/0", busy, req_ready);
        end
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        cfg_len = 8'd4;
        stim[0] = 32'd3; stim[1] = 32'hFFFF_FFFF; stim[2] = 32'd10; stim[3] = 32'd7;
        stream(1, 4);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd19 || res_id !== 2'd1) begin
            n_fail++;
            $display("FAIL single_result got v=%b data=%0d id=%0d want v=1 data=19 id=1",
                     res_valid, $signed(res_data), res_id);
        end
        n_checks++;
        if ({obs_init[3], obs_init[2], obs_init[1], obs_init[0]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_init got %b%b%b%b want 0001",
                     obs_init[3], obs_init[2], obs_init[1], obs_init[0]);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) if (obs_in[k] !== stim[k]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL single_in_data got %0d wrong beats want 0", bad);
        end
        n_checks++;
        if (req_ready !== '0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_done_ready got ready=%b busy=%b want 0000/1", req_ready, busy);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_return_idle got busy=%b rv=%b want 0/0", busy, res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int got; int cyc; int last_cyc; int onehot_bad; int data_bad; int order_bad;
        apply_reset();
        cfg_len = 8'd2; req_valid = '1; req_data = {N{32'd1}}; res_ready = 1'b1;
        got = 0; cyc = 0; last_cyc = -1; onehot_bad = 0; data_bad = 0; order_bad = 0;
        while (got < 5 && cyc < 60) begin
            #1;
            if ($countones(req_ready) > 1) onehot_bad++;
            if (res_valid && res_ready) begin
                if (res_id !== IW'(got % N)) order_bad++;
                if (res_data !== 32'd2) data_bad++;
                got++;
                last_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0; res_ready = 1'b0;
        n_checks++;
        if (got != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", got); end
        n_checks++;
        if (order_bad != 0) begin n_fail++; $display("FAIL rr_order got %0d out-of-order want 0", order_bad); end
        n_checks++;
        if (data_bad != 0) begin n_fail++; $display("FAIL rr_data got %0d wrong sums want 0", data_bad); end
        n_checks++;
        if (onehot_bad != 0) begin n_fail++; $display("FAIL rr_onehot got %0d cycles want 0", onehot_bad); end
        // Each burst takes IDLE + 2 beats + DONE = 4 cycles; the 5th sum lands at cycle 3+4*4.
        n_checks++;
        if (last_cyc != 19) begin n_fail++; $display("FAIL rr_turnaround got cycle %0d want 19", last_cyc); end
    endtask

    task automatic test_bubbles();
        apply_reset();
        cfg_len = 8'd3;
        stim[0] = 32'd5; stim[1] = 32'd6; stim[2] = 32'hFFFF_FFFC;
        gap[0] = 0; gap[1] = 2; gap[2] = 1;
        stream(2, 3);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd7 || res_id !== 2'd2) begin
            n_fail++;
            $display("FAIL bubble_result got v=%b data=%0d id=%0d want v=1 data=7 id=2",
                     res_valid, $signed(res_data), res_id);
        end
        n_checks++;
        if (bubble_bad != 0) begin n_fail++; $display("FAIL bubble_drive got %0d bad cycles want 0", bubble_bad); end
        n_checks++;
        if ({obs_init[2], obs_init[1], obs_init[0]} !== 3'b001) begin
            n_fail++; $display("FAIL bubble_init got %b%b%b want 001", obs_init[2], obs_init[1], obs_init[0]);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_stall();
        apply_reset();
        cfg_len = 8'd2;
        stim[0] = 32'd60; stim[1] = 32'd40;
        stream(0, 2);
        for (int c = 0; c < 5; c++) begin
            req_valid[3] = ~req_valid[3];
            req_valid[1] = (c % 2 == 0);
            #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 32'd100 || req_ready !== '0 || res_id !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d got v=%b data=%0d ready=%b id=%0d want v=1 data=100 ready=0000 id=0",
                         c, res_valid, $signed(res_data), req_ready, res_id);
            end
            @(posedge clk); #1;
        end
        req_valid = '0; res_ready = 1'b1;
        #1;
        n_checks++;
        if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got rv=%b want 1", res_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle got busy=%b rv=%b want 0/0", busy, res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_len_zero_and_wrap();
        apply_reset();
        cfg_len = 8'd0;
        stim[0] = 32'd42;
        stream(1, 1);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd42 || res_id !== 2'd1) begin
            n_fail++;
            $display("FAIL len_zero got v=%b data=%0d id=%0d want v=1 data=42 id=1", res_valid, res_data, res_id);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        cfg_len = 8'd2;
        stim[0] = 32'h7FFF_FFFF; stim[1] = 32'd1;
        stream(3, 2);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h8000_0000 || res_id !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap got v=%b data=%h id=%0d want v=1 data=80000000 id=3", res_valid, res_data, res_id);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        cfg_len = 8'd4;
        stim[0] = 32'd1; stim[1] = 32'd2;
        stream(1, 2);
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL midburst_state got busy=%b ready=%b want 1/0010", busy, req_ready);
        end
        rst = 1'b1; req_valid = 4'b0010; res_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({req_ready, acc_initialize, acc_in_data, res_valid, res_id, busy, res_data} !== '0) begin
            n_fail++;
            $display("FAIL midburst_reset got ready=%b init=%b in=%h rv=%b id=%0d busy=%b data=%h want all 0",
                     req_ready, acc_initialize, acc_in_data, res_valid, res_id, busy, res_data);
        end
        rst = 1'b0; req_valid = 4'b1000; res_ready = 1'b0;
        req_data[3*DW +: DW] = 32'd1000;
        cfg_len = 8'd2;
        stim[0] = 32'd8; stim[1] = 32'd9;
        // With rr_ptr back at 0, requester 0 must win over requester 3.
        stream(0, 2);
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 32'd17) begin
            n_fail++;
            $display("FAIL fresh_burst got v=%b id=%0d data=%0d want v=1 id=0 data=17", res_valid, res_id, res_data);
        end
        req_valid = '0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        int drv_idx [N];
        int mdl_idx [N];
        int mdl_ptr; bit mdl_idle; bit draining;
        int exp_id [$];
        logic [AW-1:0] exp_sum [$];
        int n_res; int id; int len; int pid;
        logic [AW-1:0] sum; logic [AW-1:0] psum;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            drv_idx[i] = 0; mdl_idx[i] = 0;
            for (int k = 0; k < SAMP; k++) samp[i][k] = $urandom;
        end
        mdl_ptr = 0; mdl_idle = 1'b1; draining = 1'b0; n_res = 0;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            if (cyc == 900) draining = 1'b1;
            if (draining && !busy && exp_id.size() == 0) break;
            cfg_len   = LW'($urandom_range(0, 5));
            res_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) req_valid[i] = ($urandom_range(0, 3) != 0);
                else req_valid[i] = !draining && ($urandom_range(0, 9) < 6);
                req_data[i*DW +: DW] = samp[i][drv_idx[i]];
            end
            #1;
            n_checks++;
            if (busy !== !mdl_idle) begin
                n_fail++; $display("FAIL rand_busy cycle %0d got %b want %b", cyc, busy, !mdl_idle);
            end
            n_checks++;
            if ($countones(req_ready) > 1) begin
                n_fail++; $display("FAIL rand_onehot cycle %0d got ready=%b want at most one bit", cyc, req_ready);
            end
            if (mdl_idle && req_valid != '0) begin
                id = -1;
                for (int k = 0; k < N; k++)
                    if (id < 0 && req_valid[(mdl_ptr + k) % N]) id = (mdl_ptr + k) % N;
                len = (cfg_len == '0) ? 1 : int'(cfg_len);
                sum = '0;
                for (int j = 0; j < len; j++) sum += samp[id][mdl_idx[id] + j];
                mdl_idx[id] += len;
                mdl_ptr = (id + 1) % N;
                exp_id.push_back(id);
                exp_sum.push_back(sum);
                mdl_idle = 1'b0;
            end
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) drv_idx[i]++;
            if (res_valid && res_ready) begin
                n_checks++;
                if (exp_id.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected got id=%0d data=%h want no result", res_id, res_data);
                end else begin
                    pid  = exp_id.pop_front();
                    psum = exp_sum.pop_front();
                    if (res_id !== IW'(pid) || res_data !== psum) begin
                        n_fail++;
                        $display("FAIL rand_result #%0d got id=%0d data=%h want id=%0d data=%h",
                                 n_res, res_id, res_data, pid, psum);
                    end
                end
                n_res++;
                mdl_idle = 1'b1;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_id.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_drain got %0d pending busy=%b want 0/0", exp_id.size(), busy);
        end
        n_checks++;
        if (n_res < 20) begin n_fail++; $display("FAIL rand_volume got %0d results want >= 20", n_res); end
        req_valid = '0; res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_len = '0; req_valid = '0; req_data = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_bubbles();
        test_stall();
        test_len_zero_and_wrap();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
